// File: rtl/i2c_bus_watchdog.sv
// Stuck-bus watchdog for the CPLD I2C port: times SCL/SDA held low on the 1 ms tick,
// then runs 9-clock + STOP recovery with bounded retries and reports a sticky fault.
`timescale 1ns/1ps

module i2c_bus_watchdog #(
    parameter int unsigned TIMEOUT_TICKS = 1000,
    parameter int unsigned SCL_HALF      = 100,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       wd_en,
    input  logic       tick_1ms,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       clr_fault,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       recover_busy,
    output logic       bus_fault,
    output logic [3:0] recover_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        MONITOR,
        RECOVER_CLK,
        RECOVER_STOP,
        FAULT
    } state_e;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_TICKS);
    localparam logic [15:0] HALF_LAST = 16'(SCL_HALF - 1);
    localparam logic [3:0]  RETRY_C   = 4'(MAX_RETRY);

    state_e      state_q, state_d;
    logic        scl_meta_q, scl_s_q, scl_prev_q;
    logic        sda_meta_q, sda_s_q, sda_prev_q;
    logic [15:0] stuck_q, stuck_d;
    logic [15:0] half_q, half_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [3:0]  retry_q, retry_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        fault_q, fault_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;

    logic        activity;
    logic        half_done;
    logic [3:0]  bit_next;
    logic [3:0]  retry_next;

    // Pins idle high, so the synchronizer resets to the released level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_meta_q <= 1'b1;
            scl_s_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_in;
            scl_s_q    <= scl_meta_q;
            scl_prev_q <= scl_s_q;
            sda_meta_q <= sda_in;
            sda_s_q    <= sda_meta_q;
            sda_prev_q <= sda_s_q;
        end
    end

    assign activity   = (scl_s_q != scl_prev_q) || (sda_s_q != sda_prev_q) || (scl_s_q && sda_s_q);
    assign half_done  = (half_q == HALF_LAST);
    assign bit_next   = bit_q + 4'd1;
    assign retry_next = retry_q + 4'd1;

    always_comb begin
        stuck_d = stuck_q;
        if (state_q != MONITOR || activity) begin
            stuck_d = '0;
        end else if (tick_1ms && stuck_q != 16'hFFFF) begin
            stuck_d = stuck_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        retry_d = retry_q;
        rcnt_d  = rcnt_q;
        fault_d = fault_q;

        case (state_q)
            IDLE: begin
                half_d  = '0;
                phase_d = '0;
                bit_d   = '0;
                retry_d = '0;
                if (wd_en) state_d = MONITOR;
            end
            MONITOR: begin
                if (stuck_q == TIMEOUT_C) begin
                    state_d = RECOVER_CLK;
                    half_d  = '0;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            RECOVER_CLK: begin
                if (!half_done) begin
                    half_d = half_q + 16'd1;
                end else begin
                    half_d = '0;
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                    end else begin
                        phase_d = 2'd0;
                        bit_d   = bit_next;
                        if (sda_s_q || bit_next == 4'd9) state_d = RECOVER_STOP;
                    end
                end
            end
            RECOVER_STOP: begin
                if (!half_done) begin
                    half_d = half_q + 16'd1;
                end else begin
                    half_d = '0;
                    if (phase_q != 2'd2) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        phase_d = '0;
                        // Success is judged on the synced pins at the very end of phase C
                        if (scl_s_q && sda_s_q) begin
                            if (rcnt_q != 4'hF) rcnt_d = rcnt_q + 4'd1;
                            retry_d = '0;
                            state_d = MONITOR;
                        end else begin
                            retry_d = retry_next;
                            bit_d   = '0;
                            state_d = (retry_next == RETRY_C) ? FAULT : RECOVER_CLK;
                        end
                    end
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    state_d = IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!wd_en) state_d = IDLE;

        if (state_d == FAULT && state_q != FAULT) begin
            fault_d = 1'b1;
        end else if (clr_fault) begin
            fault_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_comb begin
        busy_d   = (state_d == RECOVER_CLK) || (state_d == RECOVER_STOP);
        scl_oe_d = busy_d && (phase_d == 2'd0);
        sda_oe_d = (state_d == RECOVER_STOP) && (phase_d != 2'd2);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            stuck_q  <= '0;
            half_q   <= '0;
            phase_q  <= '0;
            bit_q    <= '0;
            retry_q  <= '0;
            rcnt_q   <= '0;
            fault_q  <= 1'b0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stuck_q  <= stuck_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            retry_q  <= retry_d;
            rcnt_q   <= rcnt_d;
            fault_q  <= fault_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
        end
    end

    assign scl_oe       = scl_oe_q;
    assign sda_oe       = sda_oe_q;
    assign recover_busy = busy_q;
    assign bus_fault    = fault_q;
    assign recover_cnt  = rcnt_q;

endmodule

// File: tb/tb_i2c_bus_watchdog.sv
// Bench for i2c_bus_watchdog: expected pin-drive sequences are queued per scenario and
// compared cycle by cycle once recovery starts; counters and flags are checked directly.
`timescale 1ns/1ps

module tb_i2c_bus_watchdog;

    localparam int TIMEOUT = 4;
    localparam int HALF    = 2;
    localparam int RETRIES = 2;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       wd_en     = 1'b0;
    logic       tick_1ms  = 1'b0;
    logic       scl_in    = 1'b1;
    logic       sda_in    = 1'b1;
    logic       clr_fault = 1'b0;
    logic       scl_oe;
    logic       sda_oe;
    logic       recover_busy;
    logic       bus_fault;
    logic [3:0] recover_cnt;

    int         compareCount  = 0;
    int         mismatchCount = 0;
    logic [2:0] expQ[$];
    logic [2:0] expWord;
    bit         tracking = 1'b0;
    int         rises;
    logic       prevOe;
    bit         found;

    i2c_bus_watchdog #(
        .TIMEOUT_TICKS(TIMEOUT),
        .SCL_HALF(HALF),
        .MAX_RETRY(RETRIES)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .wd_en(wd_en),
        .tick_1ms(tick_1ms),
        .scl_in(scl_in),
        .sda_in(sda_in),
        .clr_fault(clr_fault),
        .scl_oe(scl_oe),
        .sda_oe(sda_oe),
        .recover_busy(recover_busy),
        .bus_fault(bus_fault),
        .recover_cnt(recover_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic scl, input logic sda, input int settle);
        scl_in = scl;
        sda_in = sda;
        stepCycles(settle);
    endtask

    task automatic pulseTick();
        tick_1ms = 1'b1;
        @(negedge sys_clk);
        tick_1ms = 1'b0;
    endtask

    task automatic tickRun(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) stepCycles(9);
            pulseTick();
        end
    endtask

    // Queue words are {scl_oe, sda_oe, recover_busy}, one per cycle
    task automatic pushAttempt(input int clocks);
        for (int i = 0; i < clocks; i++) begin
            for (int j = 0; j < HALF; j++) expQ.push_back(3'b101);
            for (int j = 0; j < HALF; j++) expQ.push_back(3'b001);
        end
        for (int j = 0; j < HALF; j++) expQ.push_back(3'b111);
        for (int j = 0; j < HALF; j++) expQ.push_back(3'b011);
        for (int j = 0; j < HALF; j++) expQ.push_back(3'b001);
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int w = 0;
        while (expQ.size() != 0 && w < budget) begin
            @(negedge sys_clk);
            w++;
        end
        if (expQ.size() != 0) begin
            checkOutput(tag, expQ.size(), 0);
            expQ.delete();
        end
    endtask

    task automatic waitSclOe(input string tag, input int budget);
        int w = 0;
        while (scl_oe !== 1'b1 && w < budget) begin
            @(negedge sys_clk);
            w++;
        end
        if (scl_oe !== 1'b1) checkOutput(tag, scl_oe, 1);
    endtask

    task automatic waitNotBusy(input string tag, input int budget);
        int w = 0;
        while (recover_busy !== 1'b0 && w < budget) begin
            @(negedge sys_clk);
            w++;
        end
        if (recover_busy !== 1'b0) checkOutput(tag, recover_busy, 0);
    endtask

    // Scoreboard consumer: starts on the first driven SCL low and pops one word per cycle
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!tracking && expQ.size() != 0 && scl_oe === 1'b1) tracking = 1'b1;
            if (tracking) begin
                if (expQ.size() != 0) begin
                    expWord = expQ.pop_front();
                    checkOutput("seq", {scl_oe, sda_oe, recover_busy}, expWord);
                end
                if (expQ.size() == 0) tracking = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_scl_oe", scl_oe, 0);
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_busy", recover_busy, 0);
        checkOutput("rst_fault", bus_fault, 0);
        checkOutput("rst_cnt", recover_cnt, 0);
        stepCycles(3);
        sys_rst_n = 1'b1;
        wd_en     = 1'b1;
        stepCycles(3);

        // SCL low but toggling once between ticks never times out
        applyStimulus(1'b0, 1'b1, 5);
        for (int i = 0; i < 6; i++) begin
            pulseTick();
            stepCycles(4);
            scl_in = 1'b1;
            stepCycles(2);
            scl_in = 1'b0;
            stepCycles(3);
        end
        checkOutput("toggle_busy", recover_busy, 0);
        checkOutput("toggle_scl_oe", scl_oe, 0);

        // SCL held low: timeout one cycle after the 4th counted tick
        stepCycles(5);
        tickRun(3);
        stepCycles(2);
        checkOutput("three_ticks_busy", recover_busy, 0);
        stepCycles(7);
        pulseTick();
        checkOutput("timeout_pre_scl_oe", scl_oe, 0);
        stepCycles(1);
        checkOutput("timeout_scl_oe", scl_oe, 1);
        checkOutput("timeout_busy", recover_busy, 1);
        checkOutput("timeout_sda_oe", sda_oe, 0);

        // Drop enable mid-RECOVER_CLK, then re-enable with a fresh stuck counter
        wd_en = 1'b0;
        stepCycles(1);
        checkOutput("wd_drop_scl_oe", scl_oe, 0);
        checkOutput("wd_drop_busy", recover_busy, 0);
        wd_en = 1'b1;
        stepCycles(5);
        checkOutput("reenable_busy", recover_busy, 0);
        tickRun(3);
        stepCycles(2);
        checkOutput("reenable_3ticks_busy", recover_busy, 0);
        applyStimulus(1'b1, 1'b1, 5);

        // SDA stuck, released during the 3rd recovery clock: early STOP and success
        applyStimulus(1'b1, 1'b0, 5);
        pushAttempt(3);
        expQ.push_back(3'b000);
        tickRun(4);
        rises  = 0;
        prevOe = 1'b0;
        for (int w = 0; w < 100 && rises < 3; w++) begin
            @(negedge sys_clk);
            if (scl_oe === 1'b1 && prevOe === 1'b0) rises++;
            prevOe = scl_oe;
        end
        if (rises < 3) checkOutput("early_pulses_seen", rises, 3);
        sda_in = 1'b1;
        waitDrain("early_seq_drain", 100);
        stepCycles(1);
        checkOutput("early_recover_cnt", recover_cnt, 1);
        checkOutput("early_fault", bus_fault, 0);

        // SDA permanently stuck: two full attempts, then FAULT
        applyStimulus(1'b1, 1'b0, 5);
        pushAttempt(9);
        pushAttempt(9);
        expQ.push_back(3'b000);
        tickRun(4);
        waitDrain("retry_seq_drain", 300);
        stepCycles(3);
        checkOutput("fault_set", bus_fault, 1);
        checkOutput("fault_scl_oe", scl_oe, 0);
        checkOutput("fault_sda_oe", sda_oe, 0);
        checkOutput("fault_busy", recover_busy, 0);
        clr_fault = 1'b1;
        stepCycles(1);
        clr_fault = 1'b0;
        checkOutput("clr_fault", bus_fault, 0);
        sda_in = 1'b1;
        stepCycles(3);
        checkOutput("post_clr_busy", recover_busy, 0);
        checkOutput("post_clr_cnt", recover_cnt, 1);

        // Reset during STOP phase B releases both lines asynchronously
        applyStimulus(1'b1, 1'b0, 5);
        tickRun(4);
        found = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge sys_clk);
            if (scl_oe === 1'b0 && sda_oe === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) checkOutput("phase_b_seen", found, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("midrst_scl_oe", scl_oe, 0);
        checkOutput("midrst_sda_oe", sda_oe, 0);
        checkOutput("midrst_busy", recover_busy, 0);
        checkOutput("midrst_fault", bus_fault, 0);
        checkOutput("midrst_cnt", recover_cnt, 0);
        sda_in = 1'b1;
        stepCycles(2);
        sys_rst_n = 1'b1;
        stepCycles(3);

        // Sixteen quick successful recoveries: counter saturates at 15
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 5);
            tickRun(4);
            waitSclOe("sat_start", 20);
            sda_in = 1'b1;
            waitNotBusy("sat_end", 60);
            stepCycles(2);
            checkOutput("sat_cnt", recover_cnt, (i < 15) ? (i + 1) : 15);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
